mem_responder: RTL

//  Memory-side responder for the SLC-3 CPU's MAR/MDR memory interface. Accepts

---
 rtl/mem_responder_if.sv | 36 +++
 rtl/mem_responder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
//   Bundles the CPU request side (MAR/MDR/MEM_RD/MEM_WE -> MDR_in/R/ERR), the
//   async SRAM pins and the board switch/hex I/O of the SLC-3 memory responder.
//   master : CPU-side / board view (drives requests, SRAM read data, switches)
//   slave  : the responder itself
// -----------------------------------------------------------------------------
interface mem_responder_if;
  logic [15:0] MAR;        // request address
  logic [15:0] MDR;        // write data
  logic        MEM_RD;     // read request, level, held until R
  logic        MEM_WE;     // write request, level, held until R
  logic [15:0] MDR_in;     // registered read data
  logic        R;          // one-cycle completion pulse
  logic        ERR;        // sticky read+write collision flag
  logic [15:0] SRAM_ADDR;  // SRAM address
  logic [15:0] SRAM_DQ_O;  // SRAM write data
  logic [15:0] SRAM_DQ_I;  // SRAM read data
  logic        SRAM_CE_N;  // chip enable, active-low
  logic        SRAM_OE_N;  // output enable, active-low
  logic        SRAM_WE_N;  // write enable, active-low
  logic [15:0] SW;         // board switches
  logic [15:0] HEX;        // hex display register

  modport master (
    output MAR, MDR, MEM_RD, MEM_WE, SRAM_DQ_I, SW,
    input  MDR_in, R, ERR, SRAM_ADDR, SRAM_DQ_O,
           SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, HEX
  );

  modport slave (
    input  MAR, MDR, MEM_RD, MEM_WE, SRAM_DQ_I, SW,
    output MDR_in, R, ERR, SRAM_ADDR, SRAM_DQ_O,
           SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, HEX
  );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the SLC-3 MAR/MDR interface. Accepts a level
//   read/write request, runs a WAIT_STATES+1 cycle strobe window on the async
//   SRAM, returns read data on MDR_in and pulses R once. The request must drop
//   before another access is accepted (return-to-zero handshake).
//
// Ports
//   Clk      : system clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : mem_responder_if.slave (CPU request, SRAM pins, SW/HEX)
//
// Parameters
//   WAIT_STATES : extra ACCESS cycles per access (0..15)
//   IO_ADDR     : memory-mapped I/O address
//
// Optional feature
//   IO_MAP_EN : when defined, accesses to IO_ADDR bypass the SRAM; reads return
//               SW, writes load HEX. When undefined HEX is tied to zero.
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic            Clk,
  input  logic            Reset_n,
  mem_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, HOLD} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_finish;
  logic        w_io_hit;
  logic [15:0] w_rd_data;

  logic [3:0]  r_cnt;
  logic        r_wr;
  logic        r_io;
  logic [15:0] r_addr;
  logic [15:0] r_dq;
  logic [15:0] r_mdr_in;
  logic        r_r;
  logic        r_err;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;

  // I/O decode is evaluated on the live MAR at accept time only.
`ifdef IO_MAP_EN
  assign w_io_hit  = (bus.MAR == IO_ADDR);
  assign w_rd_data = r_io ? bus.SW : bus.SRAM_DQ_I;
`else
  assign w_io_hit  = 1'b0;
  assign w_rd_data = bus.SRAM_DQ_I;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.MEM_RD || bus.MEM_WE) begin
          w_accept    = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: w_state_nxt = HOLD;
      HOLD: begin
        // Wait for the CPU to drop its request so a held level cannot retrigger.
        if (!bus.MEM_RD && !bus.MEM_WE) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes are registered: they go low on the accept edge and high again on
  // the edge that leaves ACCESS, so the low window is exactly WAIT_STATES+1.
  // R is registered from DONE, so it is high in the cycle after DONE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt    <= 4'd0;
      r_wr     <= 1'b0;
      r_io     <= 1'b0;
      r_addr   <= 16'h0000;
      r_dq     <= 16'h0000;
      r_mdr_in <= 16'h0000;
      r_r      <= 1'b0;
      r_err    <= 1'b0;
      r_ce_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
    end else begin
      r_r <= (r_state == DONE);
      if (w_accept) begin
        r_addr <= bus.MAR;
        r_dq   <= bus.MDR;
        r_wr   <= bus.MEM_WE;
        r_io   <= w_io_hit;
        r_cnt  <= 4'(WAIT_STATES);
        if (bus.MEM_RD && bus.MEM_WE) r_err <= 1'b1;
        if (!w_io_hit) begin
          r_ce_n <= 1'b0;
          r_oe_n <= bus.MEM_WE;
          r_we_n <= ~bus.MEM_WE;
        end
      end
      if (r_state == ACCESS && !w_finish) r_cnt <= r_cnt - 4'd1;
      if (w_finish) begin
        r_ce_n <= 1'b1;
        r_oe_n <= 1'b1;
        r_we_n <= 1'b1;
        if (!r_wr) r_mdr_in <= w_rd_data;
      end
    end
  end

`ifdef IO_MAP_EN
  logic [15:0] r_hex;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                      r_hex <= 16'h0000;
    else if (w_finish && r_wr && r_io) r_hex <= r_dq;
  end

  assign bus.HEX = r_hex;
`else
  assign bus.HEX = 16'h0000;
`endif

  assign bus.MDR_in    = r_mdr_in;
  assign bus.R         = r_r;
  assign bus.ERR       = r_err;
  assign bus.SRAM_ADDR = r_addr;
  assign bus.SRAM_DQ_O = r_dq;
  assign bus.SRAM_CE_N = r_ce_n;
  assign bus.SRAM_OE_N = r_oe_n;
  assign bus.SRAM_WE_N = r_we_n;

endmodule
